// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: tracks predicted branches from fetch to resolution, redirects on mispredict, paces predictor updates
// Ports: enq_* record a predicted branch (enq_ready_o = not full); res_* resolve the oldest unresolved branch;
// upd_* drive the predictor update (never on adjacent cycles); redirect_* pulse the correct pc on mispredict;
// count_o is the registered occupancy; err_o is sticky on a resolve with nothing to resolve.
module branch_resolve_queue #(
  parameter int DEPTH_LOG2 = 2,
  parameter int INDEX_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq_valid_i,
  output logic                   enq_ready_o,
  input  logic [31:0]            enq_pc_i,
  input  logic                   enq_pred_taken_i,
  input  logic [31:0]            enq_pred_target_i,
  input  logic [INDEX_WIDTH-1:0] enq_index_i,
  input  logic                   res_valid_i,
  input  logic                   res_taken_i,
  input  logic [31:0]            res_target_i,
  output logic                   upd_valid_o,
  output logic                   upd_taken_o,
  output logic [INDEX_WIDTH-1:0] upd_index_o,
  output logic                   redirect_valid_o,
  output logic [31:0]            redirect_pc_o,
  output logic [DEPTH_LOG2:0]    count_o,
  output logic                   err_o
);
  localparam int D = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  logic [31:0] pc_q [D];
  logic [31:0] tgt_q [D];
  logic [INDEX_WIDTH-1:0] idx_q [D];
  logic [D-1:0] pt_q, tk_q, res_q, vld_q, vld_d;
  ptr_t head_q, rp_q, tail_q;
  logic [DEPTH_LOG2:0] count_d;
  logic enq, rsv, mis, pop;
  // Per-entry valid bits let a full queue (tail == head) still be told apart from an empty one.
  // Resolved entries form a prefix from head, so on a squash every valid unresolved entry
  // other than the one being resolved is younger and gets dropped.
  always_comb begin
    enq_ready_o = count_o != (DEPTH_LOG2+1)'(D);
    rsv = res_valid_i & vld_q[rp_q] & ~res_q[rp_q];
    mis = rsv & ((res_taken_i != pt_q[rp_q]) | (res_taken_i & (res_target_i != tgt_q[rp_q])));
    enq = enq_valid_i & enq_ready_o & ~mis;
    pop = vld_q[head_q] & res_q[head_q] & ~upd_valid_o;
    vld_d = mis ? vld_q & (res_q | (D'(1) << rp_q)) : vld_q;
    if (pop) vld_d[head_q] = 1'b0;
    if (enq) vld_d[tail_q] = 1'b1;
    count_d = '0;
    for (int i = 0; i < D; i++) count_d = count_d + (DEPTH_LOG2+1)'(vld_d[i]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      rp_q <= '0;
      tail_q <= '0;
      vld_q <= '0;
      count_o <= '0;
      upd_valid_o <= 1'b0;
      upd_taken_o <= 1'b0;
      upd_index_o <= '0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o <= '0;
      err_o <= 1'b0;
    end else begin
      vld_q <= vld_d;
      count_o <= count_d;
      upd_valid_o <= pop;
      redirect_valid_o <= mis;
      err_o <= err_o | (res_valid_i & ~rsv);
      if (enq) begin
        pc_q[tail_q] <= enq_pc_i;
        pt_q[tail_q] <= enq_pred_taken_i;
        tgt_q[tail_q] <= enq_pred_target_i;
        idx_q[tail_q] <= enq_index_i;
        res_q[tail_q] <= 1'b0;
        tail_q <= tail_q + ptr_t'(1);
      end
      if (rsv) begin
        res_q[rp_q] <= 1'b1;
        tk_q[rp_q] <= res_taken_i;
        rp_q <= rp_q + ptr_t'(1);
      end
      if (mis) begin
        tail_q <= rp_q + ptr_t'(1);
        redirect_pc_o <= res_taken_i ? res_target_i : pc_q[rp_q] + 32'd4;
      end
      if (pop) begin
        upd_index_o <= idx_q[head_q];
        upd_taken_o <= tk_q[head_q];
        head_q <= head_q + ptr_t'(1);
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: randomized and directed check of branch_resolve_queue against a queue-based model
module tb_branch_resolve_queue;
  logic clk = 0, rst = 1;
  logic enq_valid_i = 0, enq_pred_taken_i = 0, res_valid_i = 0, res_taken_i = 0;
  logic [31:0] enq_pc_i = 0, enq_pred_target_i = 0, res_target_i = 0;
  logic [8:0] enq_index_i = 0;
  logic enq_ready_o, upd_valid_o, upd_taken_o, redirect_valid_o, err_o;
  logic [8:0] upd_index_o;
  logic [31:0] redirect_pc_o;
  logic [2:0] count_o;
  int tests = 0, fails = 0;
  typedef struct {logic [31:0] pc, tg; logic pt; logic [8:0] idx; logic r, tk;} ent_t;
  ent_t q[$];
  logic m_upd = 0, m_tk = 0, m_rv = 0, m_err = 0;
  logic [8:0] m_idx = 0;
  logic [31:0] m_rpc = 0;
  branch_resolve_queue #(.DEPTH_LOG2(2), .INDEX_WIDTH(9)) dut (
    .clk(clk), .rst(rst),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o), .enq_pc_i(enq_pc_i),
    .enq_pred_taken_i(enq_pred_taken_i), .enq_pred_target_i(enq_pred_target_i), .enq_index_i(enq_index_i),
    .res_valid_i(res_valid_i), .res_taken_i(res_taken_i), .res_target_i(res_target_i),
    .upd_valid_o(upd_valid_o), .upd_taken_o(upd_taken_o), .upd_index_o(upd_index_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .count_o(count_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic compare();
    chk("count", 32'(count_o), 32'(q.size()));
    chk("enq_ready", 32'(enq_ready_o), 32'(q.size() != 4));
    chk("upd_valid", 32'(upd_valid_o), 32'(m_upd));
    chk("redirect_valid", 32'(redirect_valid_o), 32'(m_rv));
    chk("err", 32'(err_o), 32'(m_err));
    if (m_upd) begin
      chk("upd_index", 32'(upd_index_o), 32'(m_idx));
      chk("upd_taken", 32'(upd_taken_o), 32'(m_tk));
    end
    if (m_rv) chk("redirect_pc", redirect_pc_o, m_rpc);
  endtask
  task automatic do_rst();
    rst = 1;
    enq_valid_i = 0;
    res_valid_i = 0;
    @(posedge clk); #1;
    rst = 0;
    q.delete();
    m_upd = 0; m_rv = 0; m_err = 0;
    compare();
    chk("rst_upd_index", 32'(upd_index_o), 0);
    chk("rst_redirect_pc", redirect_pc_o, 0);
  endtask
  task automatic step(input logic ev, input logic [31:0] pc, input logic pt, input logic [31:0] tg,
                      input logic [8:0] idx, input logic rv, input logic rt, input logic [31:0] rtg);
    int n, nr;
    logic pop, mis;
    ent_t e;
    enq_valid_i = ev; enq_pc_i = pc; enq_pred_taken_i = pt; enq_pred_target_i = tg; enq_index_i = idx;
    res_valid_i = rv; res_taken_i = rt; res_target_i = rtg;
    n = q.size();
    nr = 0;
    while (nr < n && q[nr].r) nr++;
    pop = n > 0 && q[0].r && !m_upd;
    mis = 0;
    if (rv && nr < n) begin
      mis = (rt != q[nr].pt) || (rt && rtg != q[nr].tg);
      if (mis) m_rpc = rt ? rtg : q[nr].pc + 32'd4;
      q[nr].r = 1;
      q[nr].tk = rt;
      if (mis) while (q.size() > nr + 1) void'(q.pop_back());
    end else if (rv) m_err = 1;
    if (ev && n != 4 && !mis) begin
      e = '{pc: pc, tg: tg, pt: pt, idx: idx, r: 0, tk: 0};
      q.push_back(e);
    end
    if (pop) begin
      m_idx = q[0].idx;
      m_tk = q[0].tk;
      void'(q.pop_front());
    end
    m_upd = pop;
    m_rv = mis;
    @(posedge clk); #1;
    compare();
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    @(posedge clk); #1;
    do_rst();
    step(1, 32'h100, 1, 32'h200, 9'h0A3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 32'h200);
    idle(4);
    step(1, 32'h40, 1, 32'h80, 9'h005, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    idle(4);
    for (int i = 0; i < 3; i++) step(1, 32'h500 + 32'(i * 4), 1, 32'h280, 9'(i + 1), 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 32'h300);
    idle(4);
    for (int i = 0; i < 5; i++) step(1, 32'h600 + 32'(i * 4), 1, 32'h200, 9'(i + 16), 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 1, 32'h200);
    idle(10);
    step(0, 0, 0, 0, 0, 1, 1, 32'h200);
    idle(3);
    for (int i = 0; i < 3; i++) step(1, 32'h700, 0, 0, 9'(i + 32), 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    do_rst();
    for (int i = 0; i < 10; i++) begin
      step(1, 32'h800 + 32'(i * 8), 1, 32'h200, 9'(i + 64), 0, 0, 0);
      idle(i % 3);
      step(0, 0, 0, 0, 0, 1, 1, 32'h200);
      idle((i + 1) % 2);
    end
    idle(6);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) do_rst();
      else step($urandom_range(0, 2) != 0, $urandom, 1'($urandom_range(0, 1)),
                $urandom_range(0, 1) ? 32'h300 : 32'h200, 9'($urandom),
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) == 0 ? 32'h300 : 32'h200);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
